// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline types: privilege modes, fetch fault codes and the
// per-request context tag carried alongside each fetched instruction.
package rv32;

  typedef enum logic [1:0] {
    PRIV_U    = 2'b00,
    PRIV_S    = 2'b01,
    PRIV_RSVD = 2'b10,
    PRIV_M    = 2'b11
  } priv_mode_t;

  typedef enum logic [1:0] {
    FETCH_FAULT_NONE       = 2'd0,
    FETCH_FAULT_ACCESS     = 2'd1,
    FETCH_FAULT_MISALIGNED = 2'd2
  } fetch_fault_t;

  typedef struct packed {
    priv_mode_t priv;
    priv_mode_t mem_priv;
    logic       endian;
  } fetch_ctx_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// rv32 instruction fetch stage: owns the PC, issues one word read at a time
// and presents a context-tagged instruction or bubble to IF/ID.
// Optional feature macro IFETCH_OVERLAP_EN: request pc+4 while consuming.
module fetch_stage
  import rv32::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  input  priv_mode_t   priv_i,
  input  priv_mode_t   mem_priv_i,
  input  logic         endianness_i,
  output logic         ibus_req_o,
  output logic [31:0]  ibus_addr_o,
  input  logic         ibus_ready_i,
  input  logic         ibus_rvalid_i,
  input  logic [31:0]  ibus_rdata_i,
  input  logic         ibus_err_i,
  output logic         bubble_o,
  output logic [31:0]  pc_o,
  output priv_mode_t   priv_o,
  output priv_mode_t   mem_priv_o,
  output logic         endianness_o,
  output logic [31:0]  inst_o,
  output fetch_fault_t fault_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  fetch_ctx_t   ctx_q, ctx_d;

  logic         bubble_q, bubble_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  inst_q, inst_d;
  fetch_ctx_t   out_ctx_q, out_ctx_d;
  fetch_fault_t fault_q, fault_d;

  fetch_ctx_t   cur_ctx_s;
  logic         req_s;
  logic [31:0]  addr_s;
  logic         outstanding_s;

  assign cur_ctx_s = '{priv: priv_i, mem_priv: mem_priv_i, endian: endianness_i};
  // A read is still in flight if we are waiting and this cycle brings no response.
  assign outstanding_s = (state_q == S_WAIT) && !ibus_rvalid_i;

  // Next-state, next-PC, kill tracking and output-register update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ctx_d     = ctx_q;
    bubble_d  = bubble_q;
    out_pc_d  = out_pc_q;
    inst_d    = inst_q;
    out_ctx_d = out_ctx_q;
    fault_d   = fault_q;
    req_s     = 1'b0;
    addr_s    = word_align(pc_q);
    kill_d    = kill_q && !ibus_rvalid_i;

    if (redirect_i) begin
      pc_d   = redirect_pc_i;
      kill_d = outstanding_s || (kill_q && !ibus_rvalid_i);
      if (is_misaligned(redirect_pc_i)) begin
        state_d   = S_HOLD;
        bubble_d  = 1'b0;
        out_pc_d  = redirect_pc_i;
        inst_d    = 32'd0;
        out_ctx_d = cur_ctx_s;
        fault_d   = FETCH_FAULT_MISALIGNED;
      end else if (outstanding_s) begin
        state_d  = S_WAIT;
        bubble_d = 1'b1;
      end else begin
        state_d  = S_REQ;
        bubble_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          // Hold off while a killed read is still due back: one outstanding max.
          req_s = !kill_q;
          if (req_s && ibus_ready_i) begin
            ctx_d   = cur_ctx_s;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid_i && kill_q) begin
            state_d = S_REQ;
          end else if (ibus_rvalid_i) begin
            state_d   = S_HOLD;
            bubble_d  = 1'b0;
            out_pc_d  = pc_q;
            out_ctx_d = ctx_q;
            if (ibus_err_i) begin
              inst_d  = 32'd0;
              fault_d = FETCH_FAULT_ACCESS;
            end else begin
              inst_d  = ibus_rdata_i;
              fault_d = FETCH_FAULT_NONE;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (stall) begin
            state_d = S_HOLD;
          end else begin
            pc_d     = seq_next_pc(pc_q);
            bubble_d = 1'b1;
            state_d  = S_REQ;
`ifdef IFETCH_OVERLAP_EN
            req_s  = !kill_q;
            addr_s = word_align(seq_next_pc(pc_q));
            if (req_s && ibus_ready_i) begin
              ctx_d   = cur_ctx_s;
              state_d = S_WAIT;
            end else begin
              state_d = S_REQ;
            end
`endif
          end
        end
        default: begin
          state_d  = S_REQ;
          bubble_d = 1'b1;
          kill_d   = 1'b0;
        end
      endcase
    end
  end

  // State, PC and presented-instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_ADDR;
      kill_q    <= 1'b0;
      ctx_q     <= '{priv: PRIV_U, mem_priv: PRIV_U, endian: 1'b0};
      bubble_q  <= 1'b1;
      out_pc_q  <= 32'd0;
      inst_q    <= 32'd0;
      out_ctx_q <= '{priv: PRIV_U, mem_priv: PRIV_U, endian: 1'b0};
      fault_q   <= FETCH_FAULT_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      ctx_q     <= ctx_d;
      bubble_q  <= bubble_d;
      out_pc_q  <= out_pc_d;
      inst_q    <= inst_d;
      out_ctx_q <= out_ctx_d;
      fault_q   <= fault_d;
    end
  end

  assign ibus_req_o   = rst_n && req_s;
  assign ibus_addr_o  = addr_s;
  assign bubble_o     = bubble_q;
  assign pc_o         = out_pc_q;
  assign inst_o       = inst_q;
  assign priv_o       = out_ctx_q.priv;
  assign mem_priv_o   = out_ctx_q.mem_priv;
  assign endianness_o = out_ctx_q.endian;
  assign fault_o      = fault_q;

endmodule
